// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time to imem and
// buffers returned instructions toward decode; branch redirects flush wrong-path work.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect_valid_i,
    input  logic [31:0]  redirect_target_i,
    fetch_unit_if.master imem,
    output logic         if_valid_o,
    output logic [31:0]  if_pc_o,
    output logic [31:0]  if_instr_o,
    input  logic         id_ready_i
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             kill_q, kill_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]      fifo_instr_q [FIFO_DEPTH];

    logic [31:0] target_pc;
    logic        push;
    logic        pop;

    assign target_pc  = {redirect_target_i[31:2], 2'b00};
    assign push       = (state_q == S_WAIT) && imem.imem_rvalid && !kill_q && !redirect_valid_i;
    assign if_valid_o = (count_q != '0) && !redirect_valid_i;
    assign pop        = if_valid_o && id_ready_i;
    assign if_pc_o    = fifo_pc_q[rd_ptr_q];
    assign if_instr_o = fifo_instr_q[rd_ptr_q];

    // req_pc_q is the address of the current or outstanding request and doubles as its tag.
    assign imem.imem_req  = (state_q == S_REQ);
    assign imem.imem_addr = req_pc_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_valid_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (!redirect_valid_i && (count_q < DEPTH_C)) state_d = S_REQ;
            end
            S_REQ: begin
                if (imem.imem_gnt) begin
                    state_d = S_WAIT;
                    // With kill set, fetch_pc already holds a redirect target, not this address.
                    if (!kill_q) fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_valid_i) begin
            fetch_pc_d = target_pc;
            if ((state_q == S_REQ) || ((state_q == S_WAIT) && !imem.imem_rvalid)) kill_d = 1'b1;
        end

        if ((state_d == S_REQ) && (state_q != S_REQ)) req_pc_d = fetch_pc_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            kill_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: buffer storage is not reset; an entry is only read once count_q marks it valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= req_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a simple imem responder returns addr ^ 0xDEAD_0000 one
// cycle after grant; a second instance starts at 0xFFFF_FFFC to cover PC wrap.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_ready;
    logic        if_valid, if_valid2;
    logic [31:0] if_pc, if_instr, if_pc2, if_instr2;

    int total = 0;
    int bad   = 0;

    fetch_unit_if mem ();
    fetch_unit_if mem2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .imem              (mem),
        .if_valid_o        (if_valid),
        .if_pc_o           (if_pc),
        .if_instr_o        (if_instr),
        .id_ready_i        (id_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid_i  (1'b0),
        .redirect_target_i (32'h0),
        .imem              (mem2),
        .if_valid_o        (if_valid2),
        .if_pc_o           (if_pc2),
        .if_instr_o        (if_instr2),
        .id_ready_i        (1'b1)
    );

    always #5 clk = ~clk;

    // Memory responders: grant while enabled, answer one cycle after grant unless stalled.
    logic        gnt_en       = 1'b1;
    logic        stall_rvalid = 1'b0;
    logic        pend         = 1'b0;
    logic        pend2        = 1'b0;
    logic [31:0] pend_addr    = '0;
    logic [31:0] pend_addr2   = '0;

    always @(posedge clk) begin
        if (mem.imem_req && mem.imem_gnt) begin
            pend      <= 1'b1;
            pend_addr <= mem.imem_addr;
        end else if (mem.imem_rvalid) begin
            pend <= 1'b0;
        end
        if (mem2.imem_req && mem2.imem_gnt) begin
            pend2      <= 1'b1;
            pend_addr2 <= mem2.imem_addr;
        end else if (mem2.imem_rvalid) begin
            pend2 <= 1'b0;
        end
    end

    always @(negedge clk) begin
        mem.imem_gnt     = mem.imem_req && gnt_en;
        mem.imem_rvalid  = pend && !stall_rvalid;
        mem.imem_rdata   = pend_addr ^ 32'hDEAD_0000;
        mem2.imem_gnt    = mem2.imem_req;
        mem2.imem_rvalid = pend2;
        mem2.imem_rdata  = pend_addr2 ^ 32'hDEAD_0000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        tick();
        while (!mem.imem_req && n < 30) begin
            tick();
            n++;
        end
        check({tag, " seen"}, 32'(mem.imem_req), 32'd1);
        check({tag, " addr"}, mem.imem_addr, exp_addr);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        int n = 0;
        tick();
        while (!if_valid && n < 30) begin
            tick();
            n++;
        end
        check({tag, " seen"}, 32'(if_valid), 32'd1);
        check({tag, " pc"}, if_pc, exp_pc);
        check({tag, " instr"}, if_instr, exp_instr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        id_ready        = 1'b1;
        repeat (3) tick();
        check("reset if_valid", 32'(if_valid), 32'd0);
        check("reset imem_req", 32'(mem.imem_req), 32'd0);
        check("reset imem_req wrap", 32'(mem2.imem_req), 32'd0);

        // Straight-line fetch with immediate grant and one-cycle response.
        rst = 1'b0;
        tick();
        check("first req", 32'(mem.imem_req), 32'd1);
        check("first addr", mem.imem_addr, 32'h0000_0000);
        check("wrap first addr", mem2.imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wait req low", 32'(mem.imem_req), 32'd0);
        check("wait if_valid low", 32'(if_valid), 32'd0);
        tick();
        check("fetch0 valid", 32'(if_valid), 32'd1);
        check("fetch0 pc", if_pc, 32'h0000_0000);
        check("fetch0 instr", if_instr, 32'hDEAD_0000);
        check("fetch1 addr", mem.imem_addr, 32'h0000_0004);
        check("wrap pc0", if_pc2, 32'hFFFF_FFFC);
        check("wrap instr0", if_instr2, 32'h2152_FFFC);
        check("wrap next addr", mem2.imem_addr, 32'h0000_0000);
        tick();
        check("after pop empty", 32'(if_valid), 32'd0);
        tick();
        check("fetch1 pc", if_pc, 32'h0000_0004);
        check("fetch1 instr", if_instr, 32'hDEAD_0004);
        check("fetch2 addr", mem.imem_addr, 32'h0000_0008);
        check("wrap pc1", if_pc2, 32'h0000_0000);
        check("wrap instr1", if_instr2, 32'hDEAD_0000);
        tick();
        tick();
        check("fetch2 valid", 32'(if_valid), 32'd1);
        check("fetch2 pc", if_pc, 32'h0000_0008);
        check("fetch2 instr", if_instr, 32'hDEAD_0008);

        // Decode stalls: buffer fills to two entries and requests stop.
        id_ready = 1'b0;
        tick();
        tick();
        check("full no req", 32'(mem.imem_req), 32'd0);
        tick();
        tick();
        check("full still no req", 32'(mem.imem_req), 32'd0);
        check("full head pc", if_pc, 32'h0000_0008);
        id_ready = 1'b1;
        tick();
        check("drain head pc", if_pc, 32'h0000_000C);
        check("drain head instr", if_instr, 32'hDEAD_000C);
        check("drain no req yet", 32'(mem.imem_req), 32'd0);
        tick();
        check("resume req", 32'(mem.imem_req), 32'd1);
        check("resume addr", mem.imem_addr, 32'h0000_0010);
        check("resume empty", 32'(if_valid), 32'd0);

        // Redirect while waiting on an unanswered response.
        stall_rvalid = 1'b1;
        tick();
        check("stalled wait req", 32'(mem.imem_req), 32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_1100;
        #1;
        check("redirect1 gate", 32'(if_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        check("killed wait req", 32'(mem.imem_req), 32'd0);
        stall_rvalid = 1'b0;
        wait_req("redirect1 req", 32'h0000_1100);
        check("redirect1 dropped", 32'(if_valid), 32'd0);
        wait_valid("redirect1", 32'h0000_1100, 32'hDEAD_1100);

        // Redirect while a request is stalled by gnt=0; JALR-style target with bit 1 set.
        gnt_en = 1'b0;
        wait_valid("seq 1104", 32'h0000_1104, 32'hDEAD_1104);
        check("stall req", 32'(mem.imem_req), 32'd1);
        check("stall addr0", mem.imem_addr, 32'h0000_1108);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_20FE;
        #1;
        check("redirect2 gate", 32'(if_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        check("redirect2 flushed", 32'(if_valid), 32'd0);
        check("stall addr1", mem.imem_addr, 32'h0000_1108);
        tick();
        check("stall addr2", mem.imem_addr, 32'h0000_1108);
        gnt_en = 1'b1;
        tick();
        check("stall addr3", mem.imem_addr, 32'h0000_1108);
        wait_req("redirect2 req", 32'h0000_20FC);
        check("redirect2 dropped", 32'(if_valid), 32'd0);
        wait_valid("redirect2", 32'h0000_20FC, 32'hDEAD_20FC);

        // Redirect coinciding with a pop and an arriving response.
        id_ready = 1'b0;
        tick();
        check("pre-redirect3 head", if_pc, 32'h0000_20FC);
        check("pre-redirect3 valid", 32'(if_valid), 32'd1);
        id_ready        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_3000;
        #1;
        check("redirect3 gate", 32'(if_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        check("redirect3 no push", 32'(if_valid), 32'd0);
        check("redirect3 req", 32'(mem.imem_req), 32'd1);
        check("redirect3 addr", mem.imem_addr, 32'h0000_3000);
        wait_valid("redirect3", 32'h0000_3000, 32'hDEAD_3000);

        // Reset while a request is granted; the stray response must be ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset valid", 32'(if_valid), 32'd0);
        check("midreset req", 32'(mem.imem_req), 32'd0);
        wait_valid("after reset", 32'h0000_0000, 32'hDEAD_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
